// File: rtl/l3_mem_arbiter.sv
// Four-requester round-robin arbiter/sequencer for the dual-port L3 memory.
// Port 0 serves any read or write; port 1 serves reads only. Up to two issues per cycle.
`ifndef NUMBER_WIDTH_DATA_WIRE
`define NUMBER_WIDTH_DATA_WIRE 8
`endif

module l3_mem_arbiter #(
  parameter int W = `NUMBER_WIDTH_DATA_WIRE
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic [3:0]       req,
  input  logic [3:0]       we,
  input  logic [4*W-1:0]   addr,
  input  logic [4*W-1:0]   wdata,
  output logic [3:0]       gnt,
  output logic [3:0]       ack,
  output logic [4*W-1:0]   rdata,
  output logic             mem_we,
  output logic             mem_oe0,
  output logic             mem_oe1,
  output logic [W-1:0]     mem_addr0,
  output logic [W-1:0]     mem_addr1,
  output logic [W-1:0]     mem_wdata,
  output logic             mem_wdata_oe,
  input  logic [W-1:0]     mem_rdata0,
  input  logic [W-1:0]     mem_rdata1
);

  localparam int NREQ = 4;

  logic [1:0]      ptr;
  logic            p0_valid, p0_we, p1_valid;
  logic [1:0]      p0_idx, p1_idx;

  logic [NREQ-1:0] elig;
  logic            p0_found, p1_found, p0_sel_we;
  logic [1:0]      p0_sel, p1_sel, idx;
  logic [W-1:0]    p0_sel_addr;
  logic [NREQ-1:0] gnt_next;

  // A requester already showing gnt is masked so one request is never issued twice.
  assign elig = req & ~gnt;

  always_comb begin
    p0_found    = 1'b0;
    p0_sel      = 2'd0;
    p1_found    = 1'b0;
    p1_sel      = 2'd0;
    idx         = 2'd0;
    gnt_next    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + 2'(k);
      if (!p0_found && elig[idx]) begin
        p0_found = 1'b1;
        p0_sel   = idx;
      end
    end
    p0_sel_we   = we[p0_sel];
    p0_sel_addr = addr[int'(p0_sel)*W +: W];
    // Port 1: reads only, and never the address port 0 is writing this cycle.
    for (int k = 1; k < NREQ; k++) begin
      idx = p0_sel + 2'(k);
      if (p0_found && !p1_found && elig[idx] && !we[idx] &&
          (!p0_sel_we || addr[int'(idx)*W +: W] != p0_sel_addr)) begin
        p1_found = 1'b1;
        p1_sel   = idx;
      end
    end
    if (p0_found) gnt_next[p0_sel] = 1'b1;
    if (p1_found) gnt_next[p1_sel] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      ptr       <= 2'd0;
      gnt       <= '0;
      ack       <= '0;
      rdata     <= '0;
      p0_valid  <= 1'b0;
      p0_we     <= 1'b0;
      p0_idx    <= 2'd0;
      p1_valid  <= 1'b0;
      p1_idx    <= 2'd0;
      mem_addr0 <= '0;
      mem_addr1 <= '0;
      mem_wdata <= '0;
    end else begin
      gnt       <= gnt_next;
      p0_valid  <= p0_found;
      p0_we     <= p0_found && p0_sel_we;
      p0_idx    <= p0_sel;
      p1_valid  <= p1_found;
      p1_idx    <= p1_sel;
      mem_addr0 <= p0_found ? p0_sel_addr : '0;
      mem_addr1 <= p1_found ? addr[int'(p1_sel)*W +: W] : '0;
      mem_wdata <= (p0_found && p0_sel_we) ? wdata[int'(p0_sel)*W +: W] : '0;
      if (p0_found) ptr <= (p1_found ? p1_sel : p0_sel) + 2'd1;
      for (int i = 0; i < NREQ; i++) begin
        ack[i] <= (p0_valid && p0_idx == 2'(i)) || (p1_valid && p1_idx == 2'(i));
        if (p0_valid && !p0_we && p0_idx == 2'(i)) rdata[i*W +: W] <= mem_rdata0;
        if (p1_valid && p1_idx == 2'(i))           rdata[i*W +: W] <= mem_rdata1;
      end
    end
  end

  // Enables are gated by RES so an issue-cycle write never commits under reset.
  assign mem_we       = p0_valid && p0_we && !RES;
  assign mem_wdata_oe = mem_we;
  assign mem_oe0      = p0_valid && !p0_we && !RES;
  assign mem_oe1      = p1_valid && !RES;

endmodule

// File: tb/tb_l3_mem_arbiter.sv
// Directed bench for l3_mem_arbiter with a behavioural dual-port memory model.
`timescale 1ns/1ps
module tb_l3_mem_arbiter;
  localparam int W = 8;

  logic           CLK = 1'b0;
  logic           RES = 1'b1;
  logic [3:0]     req = '0, we = '0;
  logic [4*W-1:0] addr = '0, wdata = '0;
  logic [3:0]     gnt, ack;
  logic [4*W-1:0] rdata;
  logic           mem_we, mem_oe0, mem_oe1, mem_wdata_oe;
  logic [W-1:0]   mem_addr0, mem_addr1, mem_wdata, mem_rdata0, mem_rdata1;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] mem [256];

  l3_mem_arbiter #(.W(W)) dut (
    .CLK(CLK), .RES(RES), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata),
    .mem_we(mem_we), .mem_oe0(mem_oe0), .mem_oe1(mem_oe1),
    .mem_addr0(mem_addr0), .mem_addr1(mem_addr1),
    .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe),
    .mem_rdata0(mem_rdata0), .mem_rdata1(mem_rdata1)
  );

  always #5 CLK = ~CLK;

  // Memory model: write commits at posedge, reads are combinational.
  always @(posedge CLK) if (mem_we) mem[mem_addr0] = mem_wdata;
  assign mem_rdata0 = mem_oe0 ? mem[mem_addr0] : '0;
  assign mem_rdata1 = mem_oe1 ? mem[mem_addr1] : '0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RES = 1'b1;
    req = '0;
    tick();
    tick();
    RES = 1'b0;
  endtask

  task automatic set_req(input int i, input logic w, input logic [W-1:0] a, input logic [W-1:0] d);
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*W +: W]  = a;
    wdata[i*W +: W] = d;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (gnt !== 4'b0 || ack !== 4'b0 || rdata !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs gnt=%b ack=%b rdata=%h expected all zero", gnt, ack, rdata);
    end
    tests_run++;
    if ({mem_we, mem_oe0, mem_oe1, mem_wdata_oe} !== 4'b0 ||
        mem_addr0 !== '0 || mem_addr1 !== '0 || mem_wdata !== '0) begin
      tests_failed++;
      $display("FAIL reset_mem en=%b a0=%h a1=%h wd=%h expected zero",
               {mem_we, mem_oe0, mem_oe1, mem_wdata_oe}, mem_addr0, mem_addr1, mem_wdata);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    set_req(0, 1'b1, 8'h12, 8'hA5);
    tick();
    tests_run++;
    if (gnt !== 4'b0001 || mem_we !== 1'b1 || mem_wdata_oe !== 1'b1 || mem_oe0 !== 1'b0 ||
        mem_addr0 !== 8'h12 || mem_wdata !== 8'hA5) begin
      tests_failed++;
      $display("FAIL wr_issue gnt=%b we=%b oe=%b wdoe=%b a0=%h wd=%h expected 0001 1 0 1 12 a5",
               gnt, mem_we, mem_oe0, mem_wdata_oe, mem_addr0, mem_wdata);
    end
    req = '0;
    tick();
    tests_run++;
    if (ack !== 4'b0001 || mem[8'h12] !== 8'hA5 || rdata[7:0] !== 8'h00) begin
      tests_failed++;
      $display("FAIL wr_ack ack=%b mem=%h rdata0=%h expected 0001 a5 00", ack, mem[8'h12], rdata[7:0]);
    end
    set_req(0, 1'b0, 8'h12, 8'h00);
    tick();
    tests_run++;
    if (gnt !== 4'b0001 || mem_oe0 !== 1'b1 || mem_we !== 1'b0 || mem_addr0 !== 8'h12) begin
      tests_failed++;
      $display("FAIL rd_issue gnt=%b oe0=%b we=%b a0=%h expected 0001 1 0 12", gnt, mem_oe0, mem_we, mem_addr0);
    end
    req = '0;
    tick();
    tests_run++;
    if (ack !== 4'b0001 || rdata[7:0] !== 8'hA5) begin
      tests_failed++;
      $display("FAIL rd_ack ack=%b rdata0=%h expected 0001 a5", ack, rdata[7:0]);
    end
  endtask

  task automatic test_dual_read();
    do_reset();
    mem[8'h04] = 8'h44;
    mem[8'h08] = 8'h88;
    set_req(1, 1'b0, 8'h04, 8'h00);
    set_req(2, 1'b0, 8'h08, 8'h00);
    tick();
    tests_run++;
    if (gnt !== 4'b0110 || mem_oe0 !== 1'b1 || mem_oe1 !== 1'b1 ||
        mem_addr0 !== 8'h04 || mem_addr1 !== 8'h08) begin
      tests_failed++;
      $display("FAIL dual_issue gnt=%b oe0=%b oe1=%b a0=%h a1=%h expected 0110 1 1 04 08",
               gnt, mem_oe0, mem_oe1, mem_addr0, mem_addr1);
    end
    req = '0;
    tick();
    tests_run++;
    if (ack !== 4'b0110 || rdata[15:8] !== 8'h44 || rdata[23:16] !== 8'h88) begin
      tests_failed++;
      $display("FAIL dual_ack ack=%b r1=%h r2=%h expected 0110 44 88", ack, rdata[15:8], rdata[23:16]);
    end
  endtask

  task automatic test_write_serial();
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'h10 + 8'(i), 8'hC0 + 8'(i));
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (gnt !== (4'b0001 << k) || mem_we !== 1'b1 || mem_oe1 !== 1'b0) begin
        tests_failed++;
        $display("FAIL wser_gnt%0d gnt=%b we=%b oe1=%b expected %b 1 0", k, gnt, mem_we, mem_oe1, 4'b0001 << k);
      end
      req = req & ~gnt;
    end
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (mem[8'h10 + 8'(i)] !== 8'hC0 + 8'(i)) begin
        tests_failed++;
        $display("FAIL wser_mem%0d got=%h expected %h", i, mem[8'h10 + 8'(i)], 8'hC0 + 8'(i));
      end
    end
  endtask

  task automatic test_raw_guard();
    do_reset();
    mem[8'h30] = 8'h11;
    set_req(0, 1'b1, 8'h30, 8'h5A);
    set_req(1, 1'b0, 8'h30, 8'h00);
    tick();
    tests_run++;
    if (gnt !== 4'b0001 || mem_oe1 !== 1'b0 || mem_we !== 1'b1) begin
      tests_failed++;
      $display("FAIL raw_issue gnt=%b oe1=%b we=%b expected 0001 0 1", gnt, mem_oe1, mem_we);
    end
    req[0] = 1'b0;
    tick();
    tests_run++;
    if (gnt !== 4'b0010 || ack !== 4'b0001 || mem_oe0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL raw_defer gnt=%b ack=%b oe0=%b expected 0010 0001 1", gnt, ack, mem_oe0);
    end
    req[1] = 1'b0;
    tick();
    tests_run++;
    if (ack !== 4'b0010 || rdata[15:8] !== 8'h5A) begin
      tests_failed++;
      $display("FAIL raw_ack ack=%b r1=%h expected 0010 5a", ack, rdata[15:8]);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mem[8'h40 + 8'(i)] = 8'hB0 + 8'(i);
      set_req(i, 1'b0, 8'h40 + 8'(i), 8'h00);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_g = k[0] ? 4'b1100 : 4'b0011;
      tests_run++;
      if (gnt !== exp_g || (k > 0 && ack !== ~exp_g)) begin
        tests_failed++;
        $display("FAIL fair_c%0d gnt=%b ack=%b expected %b %b", k, gnt, ack, exp_g, k > 0 ? ~exp_g : 4'b0);
      end
    end
    req = '0;
    tick();
    tests_run++;
    if (ack !== 4'b1100 || gnt !== 4'b0000 || rdata !== 32'hB3B2B1B0) begin
      tests_failed++;
      $display("FAIL fair_drain ack=%b gnt=%b rdata=%h expected 1100 0000 b3b2b1b0", ack, gnt, rdata);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    mem[8'h20] = 8'h00;
    set_req(0, 1'b1, 8'h20, 8'h77);
    tick();
    tests_run++;
    if (gnt !== 4'b0001) begin
      tests_failed++;
      $display("FAIL rmid_gnt gnt=%b expected 0001", gnt);
    end
    RES = 1'b1;
    req = '0;
    #1;
    tests_run++;
    if (mem_we !== 1'b0 || mem_wdata_oe !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmid_we we=%b wdoe=%b expected 0 0", mem_we, mem_wdata_oe);
    end
    tick();
    RES = 1'b0;
    tests_run++;
    if (ack !== 4'b0 || gnt !== 4'b0 || mem[8'h20] !== 8'h00) begin
      tests_failed++;
      $display("FAIL rmid_drop ack=%b gnt=%b mem=%h expected 0000 0000 00", ack, gnt, mem[8'h20]);
    end
    tick();
    tests_run++;
    if (ack !== 4'b0) begin
      tests_failed++;
      $display("FAIL rmid_noack ack=%b expected 0000", ack);
    end
    // Requester 3 plus 0: with ptr back at 0, requester 0 must win port 0.
    set_req(3, 1'b1, 8'h21, 8'h99);
    set_req(0, 1'b1, 8'h20, 8'h77);
    tick();
    tests_run++;
    if (gnt !== 4'b0001 || mem_we !== 1'b1 || mem_addr0 !== 8'h20) begin
      tests_failed++;
      $display("FAIL rmid_retry gnt=%b we=%b a0=%h expected 0001 1 20", gnt, mem_we, mem_addr0);
    end
    req[0] = 1'b0;
    tick();
    tests_run++;
    if (ack !== 4'b0001 || gnt !== 4'b1000 || mem[8'h20] !== 8'h77) begin
      tests_failed++;
      $display("FAIL rmid_done ack=%b gnt=%b mem=%h expected 0001 1000 77", ack, gnt, mem[8'h20]);
    end
    req = '0;
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_write_read();
    test_dual_read();
    test_write_serial();
    test_raw_guard();
    test_fairness();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
